sdram_pll_supervisor: RTL and testbench

//  Initiator side of the SDRAM/camera PLL interface. Drives the PLL's rst input and consumes its

---
 rtl/sdram_pll_pkg.sv | 45 ++++
 rtl/sdram_pll_sync2.sv | 25 ++
 rtl/sdram_pll_supervisor.sv | 131 +++++++++++++
 tb/tb_sdram_pll_supervisor.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sdram_pll_pkg.sv
// Shared state encodings, default timing and output decode
// for the SDRAM/camera PLL supervisor.
package sdram_pll_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 50;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_MAX_RETRIES         = 7;
  localparam int unsigned DEF_CNT_W               = 16;

  typedef struct packed {
    logic pll_rst;
    logic sys_rst;
    logic ready;
    logic fault;
  } outs_t;

  function automatic outs_t decode_outs(state_e s);
    outs_t o;
    o = '{pll_rst: 1'b0, sys_rst: 1'b1,
          ready: 1'b0, fault: 1'b0};
    case (s)
      ST_PLL_RST: o.pll_rst = 1'b1;
      ST_RUN: begin
        o.sys_rst = 1'b0;
        o.ready   = 1'b1;
      end
      ST_FAULT: begin
        o.pll_rst = 1'b1;
        o.fault   = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sdram_pll_sync2.sv
// Two-flop synchronizer for a single asynchronous level,
// async reset to 0.
module sdram_pll_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/sdram_pll_supervisor.sv
// PLL reset sequencer: pulses the PLL reset, waits for a
// stable lock, retries on timeout and gates the system reset.
module sdram_pll_supervisor
  import sdram_pll_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W               = DEF_CNT_W
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

  logic locked_s;

  sdram_pll_sync2 u_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  outs_t            outs_q, outs_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (restart) begin
      state_d = ST_PLL_RST;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_PLL_RST;
              retry_d = retry_q + 1'b1;
            end
          end
        end
        ST_STABLE: begin
          // A lock glitch restarts the wait without spending a retry
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          cnt_d = '0;
          if (!locked_s) begin
            state_d = ST_PLL_RST;
            if (loss_q != 8'hFF) loss_d = loss_q + 1'b1;
          end
        end
        ST_FAULT: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end
    outs_d = decode_outs(state_d);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PLL_RST;
      cnt_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
      outs_q  <= decode_outs(ST_PLL_RST);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
      outs_q  <= outs_d;
    end
  end

  assign pll_rst         = outs_q.pll_rst;
  assign sys_rst         = outs_q.sys_rst;
  assign ready           = outs_q.ready;
  assign fault           = outs_q.fault;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_sdram_pll_supervisor.sv
// Directed bench: stimulus queues expected outputs per cycle,
// a monitor pops and compares them at each falling edge.
module tb_sdram_pll_supervisor;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, sys_rst, ready, fault;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  bit clk_en = 1'b1;
  bit probe = 1'b0;
  int cyc = 0;
  int base = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    string       nm;
    logic [15:0] v;
  } exp_t;

  exp_t q[$];

  sdram_pll_supervisor #(
    .PLL_RST_CYCLES      (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2),
    .CNT_W               (16)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .restart         (restart),
    .pll_rst         (pll_rst),
    .sys_rst         (sys_rst),
    .ready           (ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  always #10 if (clk_en) refclk = ~refclk;

  always @(posedge refclk) cyc++;

  wire [15:0] act = {pll_rst, sys_rst, ready, fault,
                     retry_count, lock_loss_count};

  // fields: {pll_rst,sys_rst,ready,fault,retry[3:0],loss[7:0]}
  initial begin
    exp_t e;
    forever begin
      @(negedge refclk or posedge probe);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (act !== e.v) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%h expected=%h",
                   e.nm, e.cyc - base, act, e.v);
        end
      end
    end
  end

  function automatic void ex(int n, string nm,
                             logic p, logic s, logic r,
                             logic f, logic [3:0] rc,
                             logic [7:0] ll);
    exp_t e;
    e.cyc = base + n;
    e.nm  = nm;
    e.v   = {p, s, r, f, rc, ll};
    q.push_back(e);
  endfunction

  task automatic at(int n);
    while (cyc < base + n) @(negedge refclk);
  endtask

  task automatic release_rst();
    rst = 1'b1;
    restart = 1'b0;
    repeat (3) @(negedge refclk);
    rst = 1'b0;
    base = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    // A: nominal, lock loss in RUN, async reset mid-wait
    pll_locked = 1'b0;
    release_rst();
    ex(1,  "A_rst_hold",   1, 1, 0, 0, 0, 0);
    ex(3,  "A_pllrst_end", 1, 1, 0, 0, 0, 0);
    ex(4,  "A_wait",       0, 1, 0, 0, 0, 0);
    ex(20, "A_stable",     0, 1, 0, 0, 0, 0);
    ex(21, "A_run",        0, 0, 1, 0, 0, 0);
    ex(32, "A_run_hold",   0, 0, 1, 0, 0, 0);
    ex(33, "A_loss",       1, 1, 0, 0, 0, 1);
    ex(36, "A_repulse",    1, 1, 0, 0, 0, 1);
    ex(37, "A_rewait",     0, 1, 0, 0, 0, 1);
    ex(50, "A_restable",   0, 1, 0, 0, 0, 1);
    ex(51, "A_rerun",      0, 0, 1, 0, 0, 1);
    ex(58, "A_loss2",      1, 1, 0, 0, 0, 2);
    ex(62, "A_wait2",      0, 1, 0, 0, 0, 2);
    at(10); pll_locked = 1'b1;
    at(30); pll_locked = 1'b0;
    at(40); pll_locked = 1'b1;
    at(55); pll_locked = 1'b0;
    at(64);
    clk_en = 1'b0;
    #1 rst = 1'b1;
    #3;
    ex(64, "A_async_rst",  1, 1, 0, 0, 0, 0);
    probe = 1'b1;
    #1 probe = 1'b0;
    #5 clk_en = 1'b1;

    // B: glitch while STABLE
    pll_locked = 1'b0;
    release_rst();
    ex(17, "B_stable",     0, 1, 0, 0, 0, 0);
    ex(20, "B_glitch",     0, 1, 0, 0, 0, 0);
    ex(21, "B_no_early",   0, 1, 0, 0, 0, 0);
    ex(28, "B_stable8",    0, 1, 0, 0, 0, 0);
    ex(29, "B_run",        0, 0, 1, 0, 0, 0);
    at(10); pll_locked = 1'b1;
    at(15); pll_locked = 1'b0;
    at(18); pll_locked = 1'b1;
    at(30);

    // C: no lock -> fault, then restart out of FAULT
    pll_locked = 1'b0;
    release_rst();
    ex(3,  "C_p1_end",     1, 1, 0, 0, 0, 0);
    ex(4,  "C_w1",         0, 1, 0, 0, 0, 0);
    ex(23, "C_w1_end",     0, 1, 0, 0, 0, 0);
    ex(24, "C_p2",         1, 1, 0, 0, 1, 0);
    ex(27, "C_p2_end",     1, 1, 0, 0, 1, 0);
    ex(28, "C_w2",         0, 1, 0, 0, 1, 0);
    ex(47, "C_w2_end",     0, 1, 0, 0, 1, 0);
    ex(48, "C_p3",         1, 1, 0, 0, 2, 0);
    ex(51, "C_p3_end",     1, 1, 0, 0, 2, 0);
    ex(52, "C_w3",         0, 1, 0, 0, 2, 0);
    ex(71, "C_w3_end",     0, 1, 0, 0, 2, 0);
    ex(72, "C_fault",      1, 1, 0, 1, 2, 0);
    ex(80, "C_fault_hold", 1, 1, 0, 1, 2, 0);
    ex(81, "C_restart",    1, 1, 0, 0, 0, 0);
    ex(84, "C_rp_end",     1, 1, 0, 0, 0, 0);
    ex(85, "C_rwait",      0, 1, 0, 0, 0, 0);
    at(80); restart = 1'b1;
    at(81); restart = 1'b0;
    at(86);

    // D: restart coincides with final timeout
    pll_locked = 1'b0;
    release_rst();
    ex(71, "D_w3_end",     0, 1, 0, 0, 2, 0);
    ex(72, "D_restart_win",1, 1, 0, 0, 0, 0);
    ex(75, "D_rp_end",     1, 1, 0, 0, 0, 0);
    ex(76, "D_wait",       0, 1, 0, 0, 0, 0);
    at(71); restart = 1'b1;
    at(72); restart = 1'b0;
    at(78);

    @(negedge refclk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending got=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
